// File: rtl/cache_ctrl_fsm_param.sv
// Cache controller FSM between the CPU request port, the tag/data arrays and
// the memory port. Supports multi-beat line write-back and fill, selectable
// write-back / write-through policy, and a memory-stall timeout that aborts
// the request with an error response.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clk edge where valid and ready are both 1; once valid is raised
// it is held, with its qualifiers stable, until that edge (a timeout abort is
// the only exception on the memory side).
module cache_ctrl_fsm_param #(
  parameter int LINE_WORDS  = 4,
  parameter bit WRITE_BACK  = 1'b1,
  parameter int TIMEOUT_CYC = 255,
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_err,
  input  logic              hit,
  input  logic              dirty,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  input  logic              mem_req_ready,
  input  logic              mem_beat_valid,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              cache_write,
  output logic              tag_write,
  output logic              set_dirty,
  output logic              clr_dirty,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB_REQ    = 3'd2,
    S_WB_DATA   = 3'd3,
    S_FILL_REQ  = 3'd4,
    S_FILL_DATA = 3'd5,
    S_WT_WRITE  = 3'd6,
    S_RESPOND   = 3'd7
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t             state_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               op_we;
  logic               err_q;
  logic               mem_wait;
  logic               mem_progress;

  // States that wait on the memory side, and whether memory moved this cycle.
  assign mem_wait     = (state_q == S_WB_REQ) || (state_q == S_WB_DATA) ||
                        (state_q == S_FILL_REQ) || (state_q == S_FILL_DATA) ||
                        (state_q == S_WT_WRITE);
  assign mem_progress = mem_req_ready ||
                        (mem_beat_valid && ((state_q == S_WB_DATA) || (state_q == S_FILL_DATA)));

  // Control state, beat counter, latched op, error flag and stall timer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      tmo_cnt <= '0;
      op_we   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_valid) begin
            op_we   <= cpu_req_we;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (op_we && !WRITE_BACK) state_q <= S_WT_WRITE;
            else                      state_q <= S_RESPOND;
          end else if (WRITE_BACK && dirty) begin
            state_q <= S_WB_REQ;
          end else if (!WRITE_BACK && op_we) begin
            state_q <= S_WT_WRITE;  // no write-allocate
          end else begin
            state_q <= S_FILL_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= S_WB_DATA;
          end
        end
        S_WB_DATA: begin
          if (mem_beat_valid) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= S_FILL_REQ;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= S_FILL_DATA;
          end
        end
        S_FILL_DATA: begin
          if (mem_beat_valid) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= S_LOOKUP;  // replay the lookup; it should now hit
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_WT_WRITE: begin
          if (mem_req_ready) state_q <= S_RESPOND;
        end
        S_RESPOND: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Stall timer: any memory progress or leaving the wait states restarts it.
      if (!mem_wait || mem_progress || (TIMEOUT_CYC == 0)) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_cnt <= '0;
        beat_q  <= '0;
        err_q   <= 1'b1;
        state_q <= S_RESPOND;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Output decode from state; LOOKUP and the data phases also look at inputs.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    cache_write    = 1'b0;
    tag_write      = 1'b0;
    set_dirty      = 1'b0;
    clr_dirty      = 1'b0;
    case (state_q)
      S_IDLE:      cpu_req_ready = 1'b1;
      S_LOOKUP: begin
        if (hit && op_we) begin
          cache_write = 1'b1;
          set_dirty   = WRITE_BACK;
        end
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
      end
      S_WB_DATA:   clr_dirty = mem_beat_valid && (beat_q == LAST_BEAT);
      S_FILL_REQ:  mem_req_valid = 1'b1;
      S_FILL_DATA: begin
        cache_write = mem_beat_valid;
        tag_write   = mem_beat_valid && (beat_q == LAST_BEAT);
      end
      S_WT_WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
      end
      S_RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign beat_idx = beat_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cache_ctrl_fsm_param.sv
// Bench for cache_ctrl_fsm_param: three instances (write-back, write-through,
// write-back with short timeout), a bench-side memory responder, and a
// response scoreboard fed from a small behavioural model.
module tb_cache_ctrl_fsm_param;

  localparam int LW = 4;
  localparam int W  = 16;

  logic clk;
  logic rst_b;

  logic [2:0] cpu_req_valid, cpu_req_we, cpu_req_ready;
  logic [2:0] cpu_resp_valid, cpu_resp_err;
  logic [2:0] hit, dirty;
  logic [2:0] mem_req_valid, mem_req_we, mem_req_ready, mem_beat_valid;
  logic [2:0] cache_write, tag_write, set_dirty, clr_dirty;
  logic [1:0] beat_v  [3];
  logic [2:0] state_v [3];

  int ut_wb [3] = '{1, 0, 1};
  int ut_to [3] = '{255, 255, 8};

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic err;
    int   lat;
    int   wb_beats;
    int   clr;
    int   fill_wr;
    int   tag;
    int   lookup_wr;
    int   set_d;
    int   mem_wr;
    int   mem_rd;
    int   memv;
  } exp_t;

  cache_ctrl_fsm_param #(.LINE_WORDS(LW), .WRITE_BACK(1'b1), .TIMEOUT_CYC(255)) u_wb (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(cpu_req_valid[0]), .cpu_req_we(cpu_req_we[0]), .cpu_req_ready(cpu_req_ready[0]),
    .cpu_resp_valid(cpu_resp_valid[0]), .cpu_resp_err(cpu_resp_err[0]),
    .hit(hit[0]), .dirty(dirty[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_we(mem_req_we[0]), .mem_req_ready(mem_req_ready[0]),
    .mem_beat_valid(mem_beat_valid[0]), .beat_idx(beat_v[0]),
    .cache_write(cache_write[0]), .tag_write(tag_write[0]),
    .set_dirty(set_dirty[0]), .clr_dirty(clr_dirty[0]), .state(state_v[0]));

  cache_ctrl_fsm_param #(.LINE_WORDS(LW), .WRITE_BACK(1'b0), .TIMEOUT_CYC(255)) u_wt (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(cpu_req_valid[1]), .cpu_req_we(cpu_req_we[1]), .cpu_req_ready(cpu_req_ready[1]),
    .cpu_resp_valid(cpu_resp_valid[1]), .cpu_resp_err(cpu_resp_err[1]),
    .hit(hit[1]), .dirty(dirty[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_we(mem_req_we[1]), .mem_req_ready(mem_req_ready[1]),
    .mem_beat_valid(mem_beat_valid[1]), .beat_idx(beat_v[1]),
    .cache_write(cache_write[1]), .tag_write(tag_write[1]),
    .set_dirty(set_dirty[1]), .clr_dirty(clr_dirty[1]), .state(state_v[1]));

  cache_ctrl_fsm_param #(.LINE_WORDS(LW), .WRITE_BACK(1'b1), .TIMEOUT_CYC(8)) u_to (
    .clk(clk), .rst_b(rst_b),
    .cpu_req_valid(cpu_req_valid[2]), .cpu_req_we(cpu_req_we[2]), .cpu_req_ready(cpu_req_ready[2]),
    .cpu_resp_valid(cpu_resp_valid[2]), .cpu_resp_err(cpu_resp_err[2]),
    .hit(hit[2]), .dirty(dirty[2]),
    .mem_req_valid(mem_req_valid[2]), .mem_req_we(mem_req_we[2]), .mem_req_ready(mem_req_ready[2]),
    .mem_beat_valid(mem_beat_valid[2]), .beat_idx(beat_v[2]),
    .cache_write(cache_write[2]), .tag_write(tag_write[2]),
    .set_dirty(set_dirty[2]), .clr_dirty(clr_dirty[2]), .state(state_v[2]));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one transaction (zero request wait, `gap` idle cycles before each fill beat).
  function automatic exp_t model(input int u, input logic we, input logic h, input logic d,
                                 input int gap, input logic stall);
    exp_t e;
    e = '{err: 1'b0, lat: 0, wb_beats: 0, clr: 0, fill_wr: 0, tag: 0,
          lookup_wr: 0, set_d: 0, mem_wr: 0, mem_rd: 0, memv: 0};
    if (ut_wb[u] != 0) begin
      if (h) begin
        e.lat = 2; e.lookup_wr = int'(we); e.set_d = int'(we);
      end else if (stall) begin
        e.err = 1'b1; e.lat = 2 + ut_to[u]; e.memv = ut_to[u];
      end else begin
        e.lat = 2 + 2 + LW + gap * LW;
        if (d) begin
          e.lat += 1 + LW; e.wb_beats = LW; e.clr = 1; e.mem_wr = 1;
        end
        e.fill_wr = LW; e.tag = 1; e.mem_rd = 1;
        e.lookup_wr = int'(we); e.set_d = int'(we);
      end
    end else begin
      if (we) begin
        e.lat = 3; e.mem_wr = 1; e.lookup_wr = int'(h);
      end else if (h) begin
        e.lat = 2;
      end else begin
        e.lat = 2 + 2 + LW + gap * LW; e.fill_wr = LW; e.tag = 1; e.mem_rd = 1;
      end
    end
    return e;
  endfunction

  // Driver + memory responder + monitor for one CPU request on unit u.
  // abort_beat >= 0 returns while the fill sits at that beat index (for the reset test).
  task automatic run_txn(input int u, input logic we, input logic h, input logic d,
                         input int gap, input logic stall, input int abort_beat);
    exp_t e;
    logic [W-1:0] r;
    logic [W-1:0] got;
    int lat, gap_cnt, fill_beats, wb_beats, clr_n, fill_wr, tag_n, lk_wr, sd_n;
    int mem_wr, mem_rd, memv;
    logic done;
    logic [2:0] st;
    e = model(u, we, h, d, gap, stall);
    if (abort_beat < 0) exp_q.push_back({7'd0, e.err, e.lat[7:0]});
    gap_cnt = 0; fill_beats = 0; wb_beats = 0; clr_n = 0; fill_wr = 0; tag_n = 0;
    lk_wr = 0; sd_n = 0; mem_wr = 0; mem_rd = 0; memv = 0; done = 1'b0;
    hit[u] = h; dirty[u] = d;
    check_eq("req_ready_idle", 32'(cpu_req_ready[u]), 32'd1);
    cpu_req_valid[u] = 1'b1;
    cpu_req_we[u]    = we;
    @(posedge clk); #1;
    cpu_req_valid[u] = 1'b0;
    cpu_req_we[u]    = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      st = state_v[u];
      if (abort_beat >= 0 && st == 3'd5 && fill_beats == abort_beat) return;
      mem_req_ready[u] = (st == 3'd2 || st == 3'd4 || st == 3'd6) && !stall;
      mem_beat_valid[u] = 1'b0;
      if (st == 3'd3) mem_beat_valid[u] = 1'b1;
      else if (st == 3'd5) begin
        if (gap_cnt >= gap) begin mem_beat_valid[u] = 1'b1; gap_cnt = 0; end
        else gap_cnt++;
      end else gap_cnt = 0;
      #1;
      if (mem_req_valid[u]) memv++;
      if (mem_req_valid[u] && mem_req_ready[u] &&  mem_req_we[u]) mem_wr++;
      if (mem_req_valid[u] && mem_req_ready[u] && !mem_req_we[u]) mem_rd++;
      if (clr_dirty[u]) clr_n++;
      if (set_dirty[u]) sd_n++;
      if (st == 3'd1 && cache_write[u]) lk_wr++;
      if (st == 3'd3 && mem_beat_valid[u]) wb_beats++;
      if (st == 3'd5) begin
        check_eq("fill_beat_idx", 32'(beat_v[u]), 32'(fill_beats));
        check_eq("fill_cache_write", 32'(cache_write[u]), 32'(mem_beat_valid[u]));
        if (mem_beat_valid[u]) begin fill_wr++; fill_beats++; end
      end
      if (tag_write[u]) begin tag_n++; hit[u] = 1'b1; end
      if (cpu_resp_valid[u]) begin
        done = 1'b1;
        got  = {7'd0, cpu_resp_err[u], 8'(lat)};
        if (exp_q.size() == 0) check_eq("resp_unexpected", 32'd1, 32'd0);
        else begin
          r = exp_q.pop_front();
          check_eq("resp_err", 32'(got[8]), 32'(r[8]));
          check_eq("resp_latency", 32'(got[7:0]), 32'(r[7:0]));
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    mem_req_ready[u] = 1'b0; mem_beat_valid[u] = 1'b0;
    hit[u] = 1'b0; dirty[u] = 1'b0;
    check_eq("resp_seen", 32'(done), 32'd1);
    check_eq("resp_one_cycle", 32'(cpu_resp_valid[u]), 32'd0);
    check_eq("back_to_idle", 32'(state_v[u]), 32'd0);
    check_eq("wb_beats", 32'(wb_beats), 32'(e.wb_beats));
    check_eq("clr_dirty_cnt", 32'(clr_n), 32'(e.clr));
    check_eq("fill_writes", 32'(fill_wr), 32'(e.fill_wr));
    check_eq("tag_write_cnt", 32'(tag_n), 32'(e.tag));
    check_eq("lookup_write", 32'(lk_wr), 32'(e.lookup_wr));
    check_eq("set_dirty_cnt", 32'(sd_n), 32'(e.set_d));
    check_eq("mem_wr_acc", 32'(mem_wr), 32'(e.mem_wr));
    check_eq("mem_rd_acc", 32'(mem_rd), 32'(e.mem_rd));
    if (stall || (e.mem_wr + e.mem_rd) == 0)
      check_eq("mem_valid_cycles", 32'(memv), 32'(e.memv));
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 3; u++) begin
      check_eq({tag, "_state"}, 32'(state_v[u]), 32'd0);
      check_eq({tag, "_beat_idx"}, 32'(beat_v[u]), 32'd0);
      check_eq({tag, "_req_ready"}, 32'(cpu_req_ready[u]), 32'd1);
      check_eq({tag, "_mem_valid"}, 32'(mem_req_valid[u]), 32'd0);
      check_eq({tag, "_resp_valid"}, 32'(cpu_resp_valid[u]), 32'd0);
    end
  endtask

  initial begin
    logic rw, rh, rd;
    int rg;
    rst_b = 1'b0;
    cpu_req_valid = '0; cpu_req_we = '0; hit = '0; dirty = '0;
    mem_req_ready = '0; mem_beat_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;

    // Read hit, write-back
    run_txn(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
    // Write miss to dirty line: write-back, fill, replayed write hit
    run_txn(0, 1'b1, 1'b0, 1'b1, 0, 1'b0, -1);
    // Write-through: write miss, write hit, read miss with dirty ignored
    run_txn(1, 1'b1, 1'b0, 1'b0, 0, 1'b0, -1);
    run_txn(1, 1'b1, 1'b1, 1'b0, 0, 1'b0, -1);
    run_txn(1, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    // Fill with 3-cycle beat gaps, no timeout expected
    run_txn(0, 1'b0, 1'b0, 1'b0, 3, 1'b0, -1);
    // Memory stall on fill request trips the 8-cycle timeout, then a clean hit
    run_txn(2, 1'b0, 1'b0, 1'b0, 0, 1'b1, -1);
    run_txn(2, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
    // Random mix on the write-back unit
    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rg = int'($urandom_range(0, 2));
      run_txn(0, rw, rh, rd, rg, 1'b0, -1);
    end

    // Reset while the fill is at beat 2
    run_txn(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2);
    check_eq("pre_reset_beat_idx", 32'(beat_v[0]), 32'd2);
    rst_b = 1'b0;
    #1;
    mem_req_ready = '0; mem_beat_valid = '0; hit = '0; dirty = '0;
    check_reset_state("mid_fill_reset");
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold_mem_valid", 32'(mem_req_valid[0]), 32'd0);
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    check_eq("after_reset_mem_valid", 32'(mem_req_valid[0]), 32'd0);
    run_txn(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
